// File: rtl/interp_point_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : interp_point_loader_if
//  Description : Job stream, result stream and interpolator bus signals of
//                the interpolation point loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface interp_point_loader_if;
  // Job word stream into the loader
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  // Result stream out of the loader
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_err;
  // Interpolator side
  logic        core_rst_n;
  logic [7:0]  core_addr;
  logic        core_bus_r;
  logic        core_bus_w;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;

  // Loader side
  modport slave (
    input  s_valid, s_data, m_ready,
    input  core_addr, core_bus_r, core_bus_w, core_wdata,
    output s_ready, m_valid, m_data, m_err,
    output core_rst_n, core_rdata
  );

  // Host / interpolator side
  modport master (
    output s_valid, s_data, m_ready,
    output core_addr, core_bus_r, core_bus_w, core_wdata,
    input  s_ready, m_valid, m_data, m_err,
    input  core_rst_n, core_rdata
  );
endinterface
`default_nettype wire

// File: rtl/interp_point_loader.sv
`default_nettype none
// ============================================================================
//  Module      : interp_point_loader
//  Description : Loads an interpolation job into a private point memory,
//                runs the Lagrange interpolator out of reset, serves its
//                combinational reads and returns the result (or an error on
//                bad n / watchdog expiry) on a valid/ready stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module interp_point_loader #(
  parameter int MAX_POINTS  = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  wire logic             clk,
  input  wire logic             rst,
  interp_point_loader_if.slave  bus,
  output logic                  busy
);

  // Memory layout: n, xc, result slot, x[0..n-1], y[0..n-1]
  localparam int C_DEPTH = 3 + 2 * MAX_POINTS;
  localparam int C_AW    = $clog2(C_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_n;          // latched point count
  logic [7:0]  r_wptr;       // index of the next stream word
  logic [31:0] r_wdog;       // RUN cycle counter
  logic [31:0] r_m_data;
  logic        r_m_err;
  logic        r_core_rst_n;

  logic [31:0] mem [C_DEPTH];

  logic            w_s_ready;
  logic            w_s_hs;
  logic            w_n_ok;
  logic            w_last;
  logic            w_capture;
  logic            w_timeout;
  logic [7:0]      w_load_addr;
  logic            w_mem_we;
  logic [C_AW-1:0] w_mem_addr;
  logic [31:0]     w_mem_wdata;
  logic            w_rd_ok;

  // Nothing is accepted while reset is held, even though state reads IDLE
  assign w_s_ready = ((r_state == S_IDLE) || (r_state == S_LOAD)) && rst;
  assign w_s_hs    = bus.s_valid && w_s_ready;
  assign w_n_ok    = (bus.s_data >= 32'd2) && (bus.s_data <= 32'(MAX_POINTS));
  // Stream words run 0..2n+1; word 2n+1 closes the job
  assign w_last    = (r_wptr == ((r_n << 1) | 8'd1));
  assign w_capture = (r_state == S_RUN) && bus.core_bus_w && (bus.core_addr == 8'd2);
  assign w_timeout = (r_state == S_RUN) && (r_wdog == 32'(TIMEOUT_CYC - 1));
  // Words 0/1 land at their own index; later words skip the result slot
  assign w_load_addr = (r_wptr < 8'd2) ? r_wptr : (r_wptr + 8'd1);

  // Next-state decode and memory write port selection
  always_comb begin
    w_state_next = r_state;
    w_mem_we     = 1'b0;
    w_mem_addr   = '0;
    w_mem_wdata  = bus.s_data;
    case (r_state)
      S_IDLE: begin
        if (w_s_hs) begin
          if (w_n_ok) begin
            w_mem_we     = 1'b1;
            w_state_next = S_LOAD;
          end else begin
            w_state_next = S_ERR;
          end
        end
      end
      S_LOAD: begin
        if (w_s_hs) begin
          w_mem_we   = 1'b1;
          w_mem_addr = w_load_addr[C_AW-1:0];
          if (w_last) begin
            w_state_next = S_START;
          end
        end
      end
      S_START: w_state_next = S_RUN;
      S_RUN: begin
        // A capture in the watchdog's last cycle still wins
        if (w_capture) begin
          w_mem_we     = 1'b1;
          w_mem_addr   = C_AW'(2);
          w_mem_wdata  = bus.core_wdata;
          w_state_next = S_OUT;
        end else if (w_timeout) begin
          w_state_next = S_OUT;
        end
      end
      S_ERR: w_state_next = S_OUT;
      S_OUT: begin
        if (bus.m_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State, job bookkeeping, watchdog and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_n          <= 8'd0;
      r_wptr       <= 8'd0;
      r_wdog       <= 32'd0;
      r_m_data     <= 32'd0;
      r_m_err      <= 1'b0;
      r_core_rst_n <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      // Registered so the interpolator reset is glitch-free and high only in RUN
      r_core_rst_n <= (w_state_next == S_RUN);
      case (r_state)
        S_IDLE: begin
          if (w_s_hs && w_n_ok) begin
            r_n    <= bus.s_data[7:0];
            r_wptr <= 8'd1;
          end
        end
        S_LOAD: begin
          if (w_s_hs) begin
            r_wptr <= r_wptr + 8'd1;
          end
        end
        S_START: r_wdog <= 32'd0;
        S_RUN: begin
          r_wdog <= r_wdog + 32'd1;
          if (w_capture) begin
            r_m_data <= bus.core_wdata;
            r_m_err  <= 1'b0;
          end else if (w_timeout) begin
            r_m_data <= 32'd0;
            r_m_err  <= 1'b1;
          end
        end
        S_ERR: begin
          r_m_data <= 32'd0;
          r_m_err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Point memory write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Combinational read: the interpolator samples data_in the edge after addr
  assign w_rd_ok = (r_state == S_RUN) && bus.core_bus_r &&
                   (int'(bus.core_addr) < C_DEPTH);
  assign bus.core_rdata = w_rd_ok ? mem[bus.core_addr[C_AW-1:0]] : 32'd0;

  assign bus.s_ready    = w_s_ready;
  assign bus.m_valid    = (r_state == S_OUT);
  assign bus.m_data     = r_m_data;
  assign bus.m_err      = r_m_err;
  assign bus.core_rst_n = r_core_rst_n;
  assign busy           = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_interp_point_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interp_point_loader
//  Description : Directed bench for interp_point_loader with a small
//                Lagrange core model driving the read/write bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interp_point_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  interp_point_loader_if bus ();

  interp_point_loader #(
    .MAX_POINTS (16),
    .TIMEOUT_CYC(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int jn, jxc;
  int jx [8];
  int jy [8];
  int rb [40];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers one word (entered at a negedge, returns at a negedge after acceptance)
  task automatic send_word(input logic [31:0] d, input int gap);
    logic acc;
    bit   ok;
    if (gap > 0) begin
      bus.s_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    ok = 0;
    for (int t = 0; t < 50; t++) begin
      acc = bus.s_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_job(input int maxgap);
    send_word(32'(jn), 0);
    send_word(32'(jxc), maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
    for (int i = 0; i < jn; i++)
      send_word(32'(jx[i]), maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
    for (int i = 0; i < jn; i++)
      send_word(32'(jy[i]), maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_run();
    for (int t = 0; t < 50; t++) begin
      if (bus.core_rst_n === 1'b1) break;
      @(negedge clk);
    end
    chk("core_rst_n_rise", 32'(bus.core_rst_n), 32'd1);
  endtask

  task automatic wait_out();
    for (int t = 0; t < 200; t++) begin
      if (bus.m_valid === 1'b1) break;
      @(negedge clk);
    end
    chk("m_valid_rise", 32'(bus.m_valid), 32'd1);
  endtask

  task automatic finish_out();
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_m_valid", 32'(bus.m_valid), 32'd0);
    chk("idle_s_ready", 32'(bus.s_ready), 32'd1);
  endtask

  function automatic int lagrange();
    int n, xc, sum, num, den;
    n = rb[0];
    xc = rb[1];
    sum = 0;
    for (int i = 0; i < n; i++) begin
      num = rb[n + 3 + i];
      den = 1;
      for (int j = 0; j < n; j++) begin
        if (j != i) begin
          num = num * (xc - rb[3 + j]);
          den = den * (rb[3 + i] - rb[3 + j]);
        end
      end
      sum = sum + num / den;
    end
    return sum;
  endfunction

  // Core model: read the whole job back, check layout, write the interpolant
  task automatic core_lagrange();
    for (int a = 0; a < 2 * jn + 3; a++) begin
      if (a != 2) begin
        bus.core_bus_r = 1'b1;
        bus.core_addr  = 8'(a);
        #1 rb[a] = int'(bus.core_rdata);
        @(negedge clk);
      end
    end
    bus.core_addr = 8'd200;
    #1 chk("rd_out_of_range", bus.core_rdata, 32'd0);
    bus.core_bus_r = 1'b0;
    bus.core_addr  = 8'd0;
    #1 chk("rd_no_strobe", bus.core_rdata, 32'd0);
    @(negedge clk);
    chk("rb_n", 32'(rb[0]), 32'(jn));
    chk("rb_xc", 32'(rb[1]), 32'(jxc));
    for (int i = 0; i < jn; i++) begin
      chk("rb_x", 32'(rb[3 + i]), 32'(jx[i]));
      chk("rb_y", 32'(rb[3 + jn + i]), 32'(jy[i]));
    end
    bus.core_bus_w = 1'b1;
    bus.core_addr  = 8'd2;
    bus.core_wdata = 32'(lagrange());
    @(negedge clk);
    bus.core_bus_w = 1'b0;
  endtask

  task automatic set_job1();
    jn = 2; jxc = 3;
    jx[0] = 1;  jx[1] = 2;
    jy[0] = 10; jy[1] = 20;
  endtask

  initial begin
    int cnt;
    int extra;
    int bad_n [3];
    bus.s_valid = 1'b0;
    bus.s_data = 32'd0;
    bus.m_ready = 1'b0;
    bus.core_addr = 8'd0;
    bus.core_bus_r = 1'b0;
    bus.core_bus_w = 1'b0;
    bus.core_wdata = 32'd0;

    // Reset state
    bus.s_valid = 1'b1;
    bus.s_data  = 32'd2;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data", bus.m_data, 32'd0);
    chk("rst_m_err", 32'(bus.m_err), 32'd0);
    chk("rst_core_rst_n", 32'(bus.core_rst_n), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    bus.s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Test 1: n=2 job, result 30
    set_job1();
    load_job(0);
    wait_run();
    core_lagrange();
    wait_out();
    chk("t1_m_data", bus.m_data, 32'd30);
    chk("t1_m_err", 32'(bus.m_err), 32'd0);
    chk("t1_core_rst_n", 32'(bus.core_rst_n), 32'd0);
    finish_out();

    // Test 2: illegal n values
    bad_n[0] = 1; bad_n[1] = 0; bad_n[2] = 17;
    for (int k = 0; k < 3; k++) begin
      send_word(32'(bad_n[k]), 0);
      bus.s_data = 32'd2;
      extra = 0;
      for (int t = 0; t < 20; t++) begin
        if (bus.m_valid === 1'b1) break;
        if (bus.s_ready === 1'b1) extra++;
        @(negedge clk);
      end
      chk("t2_extra_words", 32'(extra), 32'd0);
      chk("t2_m_valid", 32'(bus.m_valid), 32'd1);
      chk("t2_m_err", 32'(bus.m_err), 32'd1);
      chk("t2_m_data", bus.m_data, 32'd0);
      chk("t2_busy", 32'(busy), 32'd1);
      bus.s_valid = 1'b0;
      finish_out();
    end

    // Test 3: n=3 with s_valid gaps, result stalled for 10 cycles
    jn = 3; jxc = 3;
    jx[0] = 0; jx[1] = 1; jx[2] = 2;
    jy[0] = 0; jy[1] = 1; jy[2] = 4;
    load_job(3);
    wait_run();
    core_lagrange();
    wait_out();
    bus.s_valid = 1'b1;
    bus.s_data  = 32'd2;
    for (int t = 0; t < 10; t++) begin
      chk("t3_m_valid", 32'(bus.m_valid), 32'd1);
      chk("t3_m_data", bus.m_data, 32'd9);
      chk("t3_s_ready", 32'(bus.s_ready), 32'd0);
      @(negedge clk);
    end
    chk("t3_m_err", 32'(bus.m_err), 32'd0);
    bus.s_valid = 1'b0;
    finish_out();

    // Test 4: core never writes, watchdog expires after 64 RUN cycles
    set_job1();
    load_job(0);
    wait_run();
    cnt = 0;
    for (int t = 0; t < 200; t++) begin
      if (bus.m_valid === 1'b1) break;
      if (bus.core_rst_n === 1'b1) cnt++;
      @(negedge clk);
    end
    chk("t4_run_cycles", 32'(cnt), 32'd64);
    chk("t4_m_valid", 32'(bus.m_valid), 32'd1);
    chk("t4_m_err", 32'(bus.m_err), 32'd1);
    chk("t4_m_data", bus.m_data, 32'd0);
    chk("t4_core_rst_n", 32'(bus.core_rst_n), 32'd0);
    finish_out();

    // Test 5: stray write to addr 5, capture in the watchdog's last cycle
    set_job1();
    load_job(0);
    wait_run();
    for (int i = 1; i <= 64; i++) begin
      bus.core_bus_r = 1'b0;
      bus.core_bus_w = 1'b0;
      if (i == 1 || i == 3) begin
        bus.core_bus_r = 1'b1;
        bus.core_addr  = 8'd5;
      end else if (i == 2) begin
        bus.core_bus_w = 1'b1;
        bus.core_addr  = 8'd5;
        bus.core_wdata = 32'hDEADBEEF;
      end else if (i == 64) begin
        bus.core_bus_w = 1'b1;
        bus.core_addr  = 8'd2;
        bus.core_wdata = 32'hDEADBEEF;
      end
      #1;
      if (i == 1 || i == 3) chk("t5_addr5", bus.core_rdata, 32'd10);
      if (i == 64) chk("t5_not_yet_out", 32'(bus.m_valid), 32'd0);
      @(negedge clk);
    end
    bus.core_bus_w = 1'b0;
    bus.core_bus_r = 1'b0;
    chk("t5_m_valid", 32'(bus.m_valid), 32'd1);
    chk("t5_m_data", bus.m_data, 32'hDEADBEEF);
    chk("t5_m_err", 32'(bus.m_err), 32'd0);
    finish_out();

    // Test 6a: reset in the middle of LOAD
    set_job1();
    send_word(32'd2, 0);
    send_word(32'd3, 0);
    send_word(32'd1, 0);
    rst = 1'b0;
    #1;
    chk("t6a_s_ready", 32'(bus.s_ready), 32'd0);
    chk("t6a_m_valid", 32'(bus.m_valid), 32'd0);
    chk("t6a_m_data", bus.m_data, 32'd0);
    chk("t6a_m_err", 32'(bus.m_err), 32'd0);
    chk("t6a_core_rst_n", 32'(bus.core_rst_n), 32'd0);
    chk("t6a_busy", 32'(busy), 32'd0);
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Test 6b: reset in the middle of RUN
    load_job(0);
    wait_run();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6b_core_rst_n", 32'(bus.core_rst_n), 32'd0);
    chk("t6b_busy", 32'(busy), 32'd0);
    chk("t6b_s_ready", 32'(bus.s_ready), 32'd0);
    chk("t6b_m_valid", 32'(bus.m_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Test 6c: a full job after the aborted ones
    load_job(0);
    wait_run();
    core_lagrange();
    wait_out();
    chk("t6c_m_data", bus.m_data, 32'd30);
    chk("t6c_m_err", 32'(bus.m_err), 32'd0);
    finish_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
